// File: rtl/seq_detector_param_if.sv
// Serial-stream bundle for seq_detector_param: qualified input bit,
// runtime pattern/mask/mode controls, and the match outputs.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din_valid;
  logic             din;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic             overlap;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_count;

  modport master (
    output din_valid, din, pattern, mask,
    output overlap, clear,
    input  match, match_count
  );

  modport slave (
    input  din_valid, din, pattern, mask,
    input  overlap, clear,
    output match, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Masked, programmable serial sequence detector with overlap control.
// Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_detector_param_if.slave bus
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_MIN = FW'(PAT_W - 1);

  // The oldest window bit is never re-read, so only PAT_W-1 are kept.
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic             match_q;
  logic [PAT_W-1:0] nxt;
  logic             cmp_ok;
  logic             hit;

  assign nxt    = {hist, bus.din};
  assign cmp_ok = ((nxt ^ bus.pattern) & bus.mask) == '0;
  assign hit    = bus.din_valid && (fill >= FILL_MIN) && cmp_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (bus.clear) begin
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (hit) begin
      match_q <= 1'b1;
      if (bus.overlap) begin
        hist <= nxt[PAT_W-2:0];
        fill <= FILL_MAX;
      end else begin
        hist <= '0;
        fill <= '0;
      end
    end else if (bus.din_valid) begin
      hist    <= nxt[PAT_W-2:0];
      fill    <= (fill == FILL_MAX) ? FILL_MAX
                                    : fill + 1'b1;
      match_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match = match_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.clear) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.match_count = cnt;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector: watches a qualified bit stream and pulses `match` when the most recent `PAT_W` accepted bits equal a runtime-programmable pattern. Don't-care bits are set through a mask. The block supports overlapping and non-overlapping detection and optionally counts matches. It replaces fixed-pattern, gate-level detectors in the Sequence_Detector design and sits directly on the serial input path.

## Interface
- `PAT_W`, default 4: pattern length in bits. Legal range is 2..32.
- `CNT_W`, default 8: width of the match counter.

- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din_valid` input 1: qualifies `din`. A bit is accepted only on edges where this is high.
- `din` input 1: serial data bit.
- `pattern` input PAT_W: target sequence. Bit 0 is compared against the newest bit.
- `mask` input PAT_W: 1 means the bit is compared; 0 means don't-care.
- `overlap` input 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `clear` input 1: synchronous flush of history, fill and counter.
- `match` output 1: one-cycle pulse on detection.
- `match_count` output CNT_W: saturating count of matches.

## Operation
- Internal state:
  - `hist[PAT_W-1:0]` shift register. On an accept it updates as `hist <= {hist[PAT_W-2:0], din}`, so the newest bit is at bit 0.
  - `fill` counter of width clog2(PAT_W+1). It counts valid history bits and saturates at `PAT_W`.
- Candidate history: `nxt = {hist[PAT_W-2:0], din}`.
- Hit condition: `din_valid` is high, `fill >= PAT_W-1`, and `((nxt ^ pattern) & mask) == 0`.
- On a hit:
  - `match` <= 1 and `match_count` increments.
  - With `overlap=1`, `hist` <= `nxt` and `fill` stays at `PAT_W`, so the trailing bits can start the next match.
  - With `overlap=0`, `hist` <= 0 and `fill` <= 0, so `PAT_W` fresh bits are needed before the next match.
- Accept with no hit: shift `hist`, `fill` <= min(`fill`+1, `PAT_W`), `match` <= 0.
- No accept (`din_valid=0`): `hist` and `fill` hold and `match` <= 0. Gaps in the stream are transparent.
- `mask` = all zeros: every accept with `fill >= PAT_W-1` is a hit.
- `pattern`, `mask` and `overlap` are sampled live on every accept. Changing them does not flush history; software changes them only while the stream is idle or together with `clear`.
- `clear` = 1: `hist`, `fill`, `match_count` <= 0 and `match` <= 0. `clear` has priority over a simultaneous accept, and that bit is discarded.
- `match_count` saturates at 2^CNT_W-1. Further hits still pulse `match` but do not wrap the counter.
- Bits are only ever counted as "fresh" after a completed shift; no partial-window matches occur.

## Timing
- Reset values while `rst_n`=0, asynchronously: `hist`=0, `fill`=0, `match`=0, `match_count`=0.
- Reset assertion mid-stream discards all history immediately. After release, `PAT_W` new accepts are required before any match.
- Latency: `match` rises on the same edge that accepts the completing bit. It is high for exactly one clock cycle, then drops unless the next edge is also a hit.
- `match_count` updates on the same edge as `match`.
- Back-to-back hits are possible:
  - With `overlap=1`, consecutive cycles can both hit, e.g. an all-ones pattern on an all-ones stream.
  - With `overlap=0`, the minimum spacing is `PAT_W` accepts.
- No combinational path from any input to any output.

## Configuration
- `SEQDET_COUNT_EN`
  - Defined: the `match_count` register and its saturation logic are built.
  - Undefined: `match_count` is tied to 0, no counter flops are inferred, and `clear` still flushes `hist` and `fill`. `match` behaviour is identical in both builds.

## Test plan
- `PAT_W=4`, `pattern=4'b1011`, `mask=4'hF`, `overlap=1`, stream 1,0,1,1,0,1,1 with `din_valid`=1 -> `match` pulses after the 4th and 7th bits; `match_count`=2.
- Same stream with `overlap=0` -> single pulse after the 4th bit; `match_count`=1.
- `mask=4'b0110`, `pattern=4'b0010`, stream 1,0,1,0 -> hit after the 4th bit, since only the two middle bits are compared. Repeat with 1,1,1,0 -> no hit.
- Stream 1,0,1,1 with `din_valid` low for 3 cycles between every bit -> single hit on the 4th accepted bit. `match` is never high while `din_valid`=0.
- `CNT_W=2`, `overlap=1`, `pattern=4'hF`, six consecutive 1s -> `match` pulses on accepts 4, 5 and 6; `match_count` stops at 3.
- `clear`=1 coincident with the completing bit -> no pulse and `match_count`=0. `rst_n` pulsed low after 3 bits of 1011 -> the 4th bit does not match after reset release.
